// File: rtl/ristretto_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches, queues in-order
// responses with their PC, and discards stale responses after a redirect.
//
// Ports:
//   clk_i, rstn_i            clock, async active-low reset
//   pb_en_i                  fetch enable
//   pb_redirect_i/_pc_i      redirect strobe and target
//   instr_req_o/addr_o       memory request and address
//   instr_ready_i            memory accepts request
//   instr_valid_i/rdata_i    memory response
//   pb_valid_o/ready_i       show-ahead head handshake
//   pb_instr_o/pc_o          head instruction and its PC
//   pb_tag_o                 fetch epoch, toggles on redirect
//   pb_busy_o                requests in flight
module ristretto_prefetch_buffer #(
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          Depth     = 4,
    parameter logic [AddrWidth-1:0] BootAddr  = '0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 pb_en_i,
    input  logic                 pb_redirect_i,
    input  logic [AddrWidth-1:0] pb_redirect_pc_i,
    output logic                 instr_req_o,
    output logic [AddrWidth-1:0] instr_addr_o,
    input  logic                 instr_ready_i,
    input  logic                 instr_valid_i,
    input  logic [DataWidth-1:0] instr_rdata_i,
    output logic                 pb_valid_o,
    input  logic                 pb_ready_i,
    output logic [DataWidth-1:0] pb_instr_o,
    output logic [AddrWidth-1:0] pb_pc_o,
    output logic                 pb_tag_o,
    output logic                 pb_busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned SumW = CntW + 1;

    logic [DataWidth-1:0] mem_data [Depth];
    logic [AddrWidth-1:0] mem_pc   [Depth];

    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW-1:0]      wr_ptr;
    logic [CntW-1:0]      count;
    logic [CntW-1:0]      outstanding;
    logic [CntW-1:0]      discard;
    logic [AddrWidth-1:0] fetch_pc;
    logic [AddrWidth-1:0] resp_pc;
    logic                 tag_q;

    logic                 credit;
    logic                 accept;
    logic                 resp;
    logic                 push;
    logic                 drop;
    logic                 pop;
    logic [AddrWidth-1:0] redir_pc;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^pb_redirect_pc_i[1:0];
    assign redir_pc = {pb_redirect_pc_i[AddrWidth-1:2], 2'b00};

    // Credit covers both queued entries and responses still owed,
    // so a push can never find the FIFO full.
    assign credit = ({1'b0, count} + {1'b0, outstanding}) < SumW'(Depth);

    // Gated with reset so the request is quiet while rstn_i is low.
    assign instr_req_o  = rstn_i & pb_en_i & ~pb_redirect_i & credit;
    assign instr_addr_o = fetch_pc;
    assign accept       = instr_req_o & instr_ready_i;

    // A response with nothing owed is spurious and ignored.
    assign resp = instr_valid_i & (outstanding != '0);
    assign push = resp & ~pb_redirect_i & (discard == '0);
    assign drop = resp & ~pb_redirect_i & (discard != '0);

    assign pb_valid_o = (count != '0);
    assign pop        = pb_valid_o & pb_ready_i & ~pb_redirect_i;
    assign pb_instr_o = pb_valid_o ? mem_data[rd_ptr] : '0;
    assign pb_pc_o    = pb_valid_o ? mem_pc[rd_ptr] : '0;
    assign pb_tag_o   = tag_q;
    assign pb_busy_o  = (outstanding != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr] <= instr_rdata_i;
            mem_pc[wr_ptr]   <= resp_pc;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= BootAddr;
            resp_pc     <= BootAddr;
            tag_q       <= 1'b0;
        end else begin
            // No request is raised during a redirect, so this also
            // covers the redirect cycle.
            outstanding <= outstanding + CntW'(accept) - CntW'(resp);
            if (pb_redirect_i) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding - CntW'(resp);
                fetch_pc <= redir_pc;
                resp_pc  <= redir_pc;
                tag_q    <= ~tag_q;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + AddrWidth'(4);
                end
                if (drop) begin
                    discard <= discard - CntW'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PtrW'(1);
                    resp_pc <= resp_pc + AddrWidth'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PtrW'(1);
                end
                count <= count + CntW'(push) - CntW'(pop);
            end
        end
    end

endmodule
